// File: rtl/float_pkg.sv
// float_pkg -- shared definitions for the integer/float converters.
// Holds the converter state encoding, the IEEE-754 single-precision field
// widths and the constants used when packing a result.
package float_pkg;

  // Operand and significand widths
  localparam int INT_W = 32;
  localparam int MAN_W = 24;

  // IEEE-754 single-precision field layout {sign, exp, frac}
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;

  // Converter sequencing, one state per processing step
  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    CONVERT_0 = 3'd1,
    NORMALISE = 3'd2,
    ROUND     = 3'd3,
    PACK      = 3'd4,
    PUT_Z     = 3'd5
  } state_t;

endpackage

// File: rtl/int2float.sv
// int2float -- converts a 32-bit two's-complement integer to an IEEE-754
// single-precision value using round-to-nearest-even.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   input_a      signed integer operand
//   input_a_stb  upstream flags input_a as valid
//   input_a_ack  high while an operand can be accepted (registered)
//   output_z     packed single-precision result (registered)
//   output_z_stb high while output_z is valid (registered)
//   output_z_ack downstream accepts output_z when high with output_z_stb
module int2float
  import float_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INT_W-1:0]  input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  output logic [INT_W-1:0]  output_z,
  output logic              output_z_stb,
  input  logic              output_z_ack
);

  state_t             state;
  logic [INT_W-1:0]   a;
  logic [INT_W-1:0]   mag;
  logic [INT_W-1:0]   z;
  logic [MAN_W-1:0]   man;
  logic [EXP_W-1:0]   exp;
  logic               sign;
  logic               guard;
  logic               round_bit;
  logic               sticky;

  // Whole conversion is a single sequencer; the normaliser shifts one bit
  // per cycle so latency depends on the leading-zero count of the magnitude.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a            <= '0;
      mag          <= '0;
      z            <= '0;
      man          <= '0;
      exp          <= '0;
      sign         <= 1'b0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= CONVERT_0;
          end else begin
            input_a_ack <= 1'b1;
          end
        end

        CONVERT_0: begin
          if (a == '0) begin
            z     <= '0;
            state <= PUT_Z;
          end else begin
            // Negating 0x80000000 wraps back to itself, which is the
            // correct unsigned magnitude for the most negative integer.
            sign  <= a[INT_W-1];
            mag   <= a[INT_W-1] ? (~a + 32'd1) : a;
            exp   <= 8'd31;
            state <= NORMALISE;
          end
        end

        NORMALISE: begin
          if (!mag[INT_W-1]) begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end else begin
            man       <= mag[31:8];
            guard     <= mag[7];
            round_bit <= mag[6];
            sticky    <= |mag[5:0];
            state     <= ROUND;
          end
        end

        ROUND: begin
          // An all-ones significand wraps to zero on increment; the
          // hidden bit moves into the exponent instead.
          if (guard && (round_bit || sticky || man[0])) begin
            man <= man + 24'd1;
            if (man == 24'hFFFFFF) begin
              exp <= exp + 8'd1;
            end
          end
          state <= PACK;
        end

        PACK: begin
          // The result is presented straight away so the non-zero path
          // does not pay an extra cycle in PUT_Z.
          z            <= {sign, exp + EXP_BIAS, man[FRAC_W-1:0]};
          output_z     <= {sign, exp + EXP_BIAS, man[FRAC_W-1:0]};
          output_z_stb <= 1'b1;
          state        <= PUT_Z;
        end

        PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
            state        <= GET_A;
          end else begin
            output_z_stb <= 1'b1;
            output_z     <= z;
          end
        end

        default: begin
          input_a_ack  <= 1'b0;
          output_z_stb <= 1'b0;
          state        <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int2float.sv
// tb_int2float -- self-checking bench for int2float.
// Directed corner cases, back-pressure hold, mid-conversion reset and a
// randomized stream checked against an arithmetic RNE reference.
module tb_int2float;

  localparam int NRAND = 1200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] expQ[$];

  always #5 clk = ~clk;

  int2float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Position of the most significant set bit of a non-zero magnitude
  function automatic int msbIndex(input longint mag);
    int e;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    return e;
  endfunction

  // Reference conversion: exact value scaled to 24 significant bits,
  // remainder compared against half an ulp for round-to-nearest-even.
  function automatic logic [31:0] refConvert(input logic [31:0] val);
    longint v, mag, q, rem, half;
    int     e, sh;
    logic   s;
    v = longint'($signed(val));
    if (v == 0) return 32'h0;
    s   = (v < 0);
    mag = s ? -v : v;
    e   = msbIndex(mag);
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), 23'(q)};
  endfunction

  // Expected edges from capture to first output_z_stb cycle
  function automatic int refLatency(input logic [31:0] val);
    longint v, mag;
    v = longint'($signed(val));
    if (v == 0) return 2;
    mag = (v < 0) ? -v : v;
    return 4 + (31 - msbIndex(mag));
  endfunction

  // Send one operand, wait for its result, optionally stall, then accept it
  task automatic applyStimulus(input logic [31:0] val, input int hold,
                               output logic [31:0] res, output int lat);
    int t;
    @(negedge clk);
    input_a = val;
    input_a_stb = 1'b1;
    t = 0;
    while (!input_a_ack && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("accept_ready", {31'b0, input_a_ack}, 32'd1);
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    input_a = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!output_z_stb && lat < 200);
    checkOutput("result_stb", {31'b0, output_z_stb}, 32'd1);
    checkOutput("ack_low_while_busy", {31'b0, input_a_ack}, 32'd0);
    res = output_z;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_z", output_z, res);
      checkOutput("hold_stb", {31'b0, output_z_stb}, 32'd1);
      checkOutput("hold_ack_low", {31'b0, input_a_ack}, 32'd0);
    end
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    checkOutput("stb_drop", {31'b0, output_z_stb}, 32'd0);
    checkOutput("ack_return", {31'b0, input_a_ack}, 32'd1);
  endtask

  // Random-gap operand source for the streaming phase
  task automatic driveRandom();
    logic [31:0] val;
    int t;
    for (int n = 0; n < NRAND; n++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: val = $urandom;
        1: val = 32'($signed($urandom_range(0, 511)) - 256);
        2: val = ($urandom & 32'h03FF_FFFF) ^ ({32{$urandom_range(0, 1) == 1}});
        default: val = ($urandom >> $urandom_range(0, 31)) ^ ({32{$urandom_range(0, 1) == 1}});
      endcase
      input_a = val;
      input_a_stb = 1'b1;
      t = 0;
      while (!input_a_ack && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        checkOutput("rand_accept_timeout", {31'b0, input_a_ack}, 32'd1);
        input_a_stb = 1'b0;
        break;
      end
      @(posedge clk);
      expQ.push_back(refConvert(val));
      #1;
      input_a_stb = 1'b0;
      input_a = $urandom;
    end
  endtask

  // Random back-pressure sink; compares each accepted result in order
  task automatic monitorRandom();
    int received, cyc;
    received = 0;
    cyc = 0;
    while (received < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      output_z_ack = ($urandom_range(0, 3) != 0);
      if (output_z_stb && output_z_ack) begin
        checkOutput("stb_ack_exclusive", {31'b0, input_a_ack}, 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("spurious_result", output_z, 32'hDEAD_BEEF);
          received = NRAND;
        end else begin
          checkOutput("rand_result", output_z, expQ.pop_front());
          received++;
        end
      end
    end
    output_z_ack = 1'b0;
    if (received < NRAND) checkOutput("rand_timeout", 32'(received), 32'(NRAND));
  endtask

  logic [31:0] dirVals [8] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF,
                              32'h8000_0000, 32'd16777217, 32'd16777219, 32'd16777221};
  logic [31:0] dirExp  [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4F00_0000,
                              32'hCF00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002};

  initial begin
    logic [31:0] res;
    int lat, seen;

    // Reset entry and release
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_ack", {31'b0, input_a_ack}, 32'd0);
    checkOutput("reset_stb", {31'b0, output_z_stb}, 32'd0);
    checkOutput("reset_z", output_z, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ack_held", {31'b0, input_a_ack}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_ack", {31'b0, input_a_ack}, 32'd1);

    // Directed values: result and latency
    for (int i = 0; i < 8; i++) begin
      applyStimulus(dirVals[i], 0, res, lat);
      checkOutput($sformatf("dir_z_%08h", dirVals[i]), res, dirExp[i]);
      checkOutput($sformatf("dir_model_%08h", dirVals[i]), res, refConvert(dirVals[i]));
      checkOutput($sformatf("dir_lat_%08h", dirVals[i]), 32'(lat), 32'(refLatency(dirVals[i])));
    end

    // Back-pressure: result held for five stalled cycles
    applyStimulus(32'd1000, 5, res, lat);
    checkOutput("stall_z", res, 32'h447A_0000);

    // Reset while normalising an operand of 1
    @(negedge clk);
    input_a = 32'd1;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset_z", output_z, 32'd0);
    checkOutput("midreset_stb", {31'b0, output_z_stb}, 32'd0);
    checkOutput("midreset_ack", {31'b0, input_a_ack}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (output_z_stb) seen++;
    end
    checkOutput("no_stale_stb", 32'(seen), 32'd0);
    applyStimulus(32'd5, 0, res, lat);
    checkOutput("after_reset_5", res, 32'h40A0_0000);

    // Randomized stream with gaps and back-pressure
    fork
      driveRandom();
      monitorRandom();
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
